// File: rtl/vliw_wb_arbiter_if.sv
//==============================================================================
// Module      : vliw_wb_arbiter_if
// Description : Bundle between the Writeback-stage lane outputs, the
//               writeback arbiter and the regfile write ports.
//               master : Writeback-stage / hazard-unit side
//                        (drives lane writes, receives port writes and status)
//               slave  : the arbiter itself
//               Inputs to arbiter : StallW, FlushW, WbValidW, WbRdW, WbDataW
//               Outputs of arbiter: we, wa, wd, PendingBusy, WbStall,
//                                   QueueCount
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface vliw_wb_arbiter_if #(
    parameter int XLEN   = 64,
    parameter int LANES  = 4,
    parameter int WPORTS = 2,
    parameter int QDEPTH = 4
);
    localparam int c_CNT_W = $clog2(QDEPTH + 1);

    logic                     StallW;
    logic                     FlushW;
    logic [LANES-1:0]         WbValidW;
    logic [5*LANES-1:0]       WbRdW;
    logic [XLEN*LANES-1:0]    WbDataW;

    logic [WPORTS-1:0]        we;
    logic [5*WPORTS-1:0]      wa;
    logic [XLEN*WPORTS-1:0]   wd;
    logic [31:0]              PendingBusy;
    logic                     WbStall;
    logic [c_CNT_W-1:0]       QueueCount;

    modport master (
        output StallW, FlushW, WbValidW, WbRdW, WbDataW,
        input  we, wa, wd, PendingBusy, WbStall, QueueCount
    );

    modport slave (
        input  StallW, FlushW, WbValidW, WbRdW, WbDataW,
        output we, wa, wd, PendingBusy, WbStall, QueueCount
    );
endinterface

`default_nettype wire

// File: rtl/vliw_wb_arbiter.sv
//==============================================================================
// Module      : vliw_wb_arbiter
// Description : Schedules integer writebacks from LANES IEU lanes onto WPORTS
//               regfile write ports. Writes that miss a port wait in a small
//               compacting FIFO and drain in later cycles.
//               clk   : clock
//               reset : asynchronous, active-low reset
//               bus   : vliw_wb_arbiter_if.slave (lane writes in; regfile
//                       ports, PendingBusy, WbStall, QueueCount out)
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module vliw_wb_arbiter #(
    parameter int XLEN   = 64,
    parameter int LANES  = 4,
    parameter int WPORTS = 2,
    parameter int QDEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    vliw_wb_arbiter_if.slave     bus
);
    // Candidate slots: queue entries first (oldest at 0), then lanes.
    localparam int c_NC       = QDEPTH + LANES;
    localparam int c_CNT_W    = $clog2(QDEPTH + 1);
    localparam int c_STALL_TH = QDEPTH - LANES + WPORTS;

    logic [c_CNT_W-1:0]  r_count;
    logic [4:0]          r_q_rd   [QDEPTH];
    logic [XLEN-1:0]     r_q_data [QDEPTH];

    logic                w_accept;
    logic [4:0]          w_lane_rd   [LANES];
    logic [XLEN-1:0]     w_lane_data [LANES];
    logic [LANES-1:0]    w_lane_req;
    logic [LANES-1:0]    w_lane_live;

    logic [c_NC-1:0]     w_cand_v;
    logic [c_NC-1:0]     w_eff;
    logic [c_NC-1:0]     w_issue;
    logic [4:0]          w_cand_rd   [c_NC];
    logic [XLEN-1:0]     w_cand_data [c_NC];

    logic [WPORTS-1:0]       w_we;
    logic [5*WPORTS-1:0]     w_wa;
    logic [XLEN*WPORTS-1:0]  w_wd;

    logic [4:0]          w_nq_rd   [QDEPTH];
    logic [XLEN-1:0]     w_nq_data [QDEPTH];
    logic [c_CNT_W-1:0]  w_next_count;
    logic [31:0]         w_pending;

    // Gating with reset keeps the ports quiet while reset is held, even if
    // the lanes still present valid writes.
    assign w_accept = reset & ~bus.StallW & ~bus.FlushW;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_lane_rd[l]   = bus.WbRdW[5*l +: 5];
        assign w_lane_data[l] = bus.WbDataW[XLEN*l +: XLEN];
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_lane_req[l] = w_accept & bus.WbValidW[l] & (w_lane_rd[l] != 5'd0);
        end
    end

    // Within a bundle the highest lane is youngest, so it wins a shared rd.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_lane_live[l] = w_lane_req[l];
            for (int j = l + 1; j < LANES; j++) begin
                if (w_lane_req[j] && (w_lane_rd[j] == w_lane_rd[l])) begin
                    w_lane_live[l] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < QDEPTH; k++) begin
            w_cand_v[k]    = (k < int'(r_count));
            w_cand_rd[k]   = r_q_rd[k];
            w_cand_data[k] = r_q_data[k];
        end
        for (int l = 0; l < LANES; l++) begin
            w_cand_v[QDEPTH+l]    = w_lane_live[l];
            w_cand_rd[QDEPTH+l]   = w_lane_rd[l];
            w_cand_data[QDEPTH+l] = w_lane_data[l];
        end
    end

    // A candidate is dead if any younger candidate targets the same rd: that
    // younger write either issues or enqueues now, superseding the older one.
    always_comb begin
        for (int k = 0; k < c_NC; k++) begin
            w_eff[k] = w_cand_v[k];
            for (int m = k + 1; m < c_NC; m++) begin
                if (w_cand_v[m] && (w_cand_rd[m] == w_cand_rd[k])) begin
                    w_eff[k] = 1'b0;
                end
            end
        end
    end

    // First WPORTS surviving candidates go to ports 0..WPORTS-1 in order.
    always_comb begin
        int n_iss;
        n_iss   = 0;
        w_issue = '0;
        w_we    = '0;
        w_wa    = '0;
        w_wd    = '0;
        for (int k = 0; k < c_NC; k++) begin
            if (w_eff[k]) begin
                for (int p = 0; p < WPORTS; p++) begin
                    if (p == n_iss) begin
                        w_issue[k]             = 1'b1;
                        w_we[p]                = 1'b1;
                        w_wa[5*p +: 5]         = w_cand_rd[k];
                        w_wd[XLEN*p +: XLEN]   = w_cand_data[k];
                    end
                end
                n_iss = n_iss + 1;
            end
        end
    end

    // Survivors that did not issue are packed into the next queue image in
    // candidate order: remaining old entries first, then new lanes.
    always_comb begin
        int n_keep;
        n_keep = 0;
        for (int s = 0; s < QDEPTH; s++) begin
            w_nq_rd[s]   = 5'd0;
            w_nq_data[s] = '0;
        end
        for (int k = 0; k < c_NC; k++) begin
            if (w_eff[k] && !w_issue[k]) begin
                for (int s = 0; s < QDEPTH; s++) begin
                    if (s == n_keep) begin
                        w_nq_rd[s]   = w_cand_rd[k];
                        w_nq_data[s] = w_cand_data[k];
                    end
                end
                n_keep = n_keep + 1;
            end
        end
        // Overflow cannot happen while the hazard unit honours WbStall.
        w_next_count = (n_keep > QDEPTH) ? c_CNT_W'(QDEPTH) : c_CNT_W'(n_keep);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            for (int s = 0; s < QDEPTH; s++) begin
                r_q_rd[s]   <= 5'd0;
                r_q_data[s] <= '0;
            end
        end else begin
            r_count  <= w_next_count;
            r_q_rd   <= w_nq_rd;
            r_q_data <= w_nq_data;
        end
    end

    always_comb begin
        w_pending = '0;
        for (int k = 0; k < QDEPTH; k++) begin
            if (k < int'(r_count)) begin
                w_pending[r_q_rd[k]] = 1'b1;
            end
        end
        w_pending[0] = 1'b0;
    end

    assign bus.we          = w_we;
    assign bus.wa          = w_wa;
    assign bus.wd          = w_wd;
    assign bus.PendingBusy = w_pending;
    assign bus.QueueCount  = r_count;
    assign bus.WbStall     = (int'(r_count) > c_STALL_TH);

endmodule

`default_nettype wire

// File: tb/tb_vliw_wb_arbiter.sv
//==============================================================================
// Module      : tb_vliw_wb_arbiter
// Description : Directed self-checking bench for vliw_wb_arbiter
//               (LANES=4, WPORTS=2, QDEPTH=4, XLEN=64).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vliw_wb_arbiter;
    localparam int c_XLEN   = 64;
    localparam int c_LANES  = 4;
    localparam int c_WPORTS = 2;
    localparam int c_QDEPTH = 4;

    logic clk;
    logic reset;

    vliw_wb_arbiter_if #(
        .XLEN(c_XLEN), .LANES(c_LANES), .WPORTS(c_WPORTS), .QDEPTH(c_QDEPTH)
    ) bus ();

    vliw_wb_arbiter #(
        .XLEN(c_XLEN), .LANES(c_LANES), .WPORTS(c_WPORTS), .QDEPTH(c_QDEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Regfile shadow built from what the ports actually write.
    logic [63:0] shadow [32] = '{default: 64'd0};
    int dup_cnt = 0;
    int x0_cnt  = 0;

    always @(posedge clk) begin
        if (reset) begin
            if (bus.we[0]) shadow[bus.wa[4:0]] <= bus.wd[63:0];
            if (bus.we[1]) shadow[bus.wa[9:5]] <= bus.wd[127:64];
            if ((&bus.we) && (bus.wa[4:0] == bus.wa[9:5])) dup_cnt <= dup_cnt + 1;
            if ((bus.we[0] && bus.wa[4:0] == 5'd0) || (bus.we[1] && bus.wa[9:5] == 5'd0))
                x0_cnt <= x0_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        bus.WbValidW = '0;
        bus.WbRdW    = '0;
        bus.WbDataW  = '0;
    endtask

    task automatic set_lane(input int l, input logic [4:0] rd, input logic [63:0] d);
        bus.WbValidW[l]        = 1'b1;
        bus.WbRdW[5*l +: 5]    = rd;
        bus.WbDataW[64*l +: 64] = d;
    endtask

    task automatic set_bundle4(input logic [4:0] rd0, input logic [63:0] d0);
        for (int l = 0; l < 4; l++) set_lane(l, rd0 + 5'(l), d0 + 64'(l));
    endtask

    logic [63:0] ref_rf [32];
    bit          ref_w  [32];
    logic [4:0]  b_rd [4];
    logic [63:0] b_d  [4];
    logic [3:0]  b_v;
    bit          have;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 32; r++) begin ref_rf[r] = 64'd0; ref_w[r] = 1'b0; end
        reset = 1'b0; bus.StallW = 1'b0; bus.FlushW = 1'b0; clear_lanes();
        #2;
        check("rst_count",   64'(bus.QueueCount), 64'd0);
        check("rst_pending", 64'(bus.PendingBusy), 64'd0);
        check("rst_we",      64'(bus.we), 64'd0);
        check("rst_wbstall", 64'(bus.WbStall), 64'd0);
        @(negedge clk); reset = 1'b1;
        tick();

        // Full bundle x5..x8, two direct, two queued.
        set_bundle4(5'd5, 64'h10);
        #1;
        check("t2_we",  64'(bus.we), 64'd3);
        check("t2_wa0", 64'(bus.wa[4:0]), 64'd5);
        check("t2_wd0", bus.wd[63:0], 64'h10);
        check("t2_wa1", 64'(bus.wa[9:5]), 64'd6);
        check("t2_wd1", bus.wd[127:64], 64'h11);
        tick(); clear_lanes(); #1;
        check("t2_count2",  64'(bus.QueueCount), 64'd2);
        check("t2_pending", 64'(bus.PendingBusy), 64'h180);
        check("t2_stall",   64'(bus.WbStall), 64'd0);
        check("t2_drain_wa0", 64'(bus.wa[4:0]), 64'd7);
        check("t2_drain_wd0", bus.wd[63:0], 64'h12);
        check("t2_drain_wa1", 64'(bus.wa[9:5]), 64'd8);
        check("t2_drain_wd1", bus.wd[127:64], 64'h13);
        tick(); #1;
        check("t2_count0",   64'(bus.QueueCount), 64'd0);
        check("t2_pend0",    64'(bus.PendingBusy), 64'd0);
        check("t2_we0",      64'(bus.we), 64'd0);
        check("t2_x8",       shadow[8], 64'h13);

        // Asynchronous reset with two queued writes in flight.
        set_bundle4(5'd5, 64'h70);
        tick(); clear_lanes(); #1;
        check("t1_count2", 64'(bus.QueueCount), 64'd2);
        #2; reset = 1'b0; #1;
        check("t1_count",   64'(bus.QueueCount), 64'd0);
        check("t1_pending", 64'(bus.PendingBusy), 64'd0);
        check("t1_we",      64'(bus.we), 64'd0);
        @(negedge clk); reset = 1'b1;
        tick();
        check("t1_rel_count", 64'(bus.QueueCount), 64'd0);
        check("t1_rel_we",    64'(bus.we), 64'd0);
        check("t1_x7_lost",   shadow[7], 64'h12);
        check("t1_x5_new",    shadow[5], 64'h70);

        // Same rd on lanes 1 and 3: only lane 3 survives.
        set_lane(1, 5'd9, 64'hA); set_lane(3, 5'd9, 64'hB);
        #1;
        check("t3_we",  64'(bus.we), 64'd1);
        check("t3_wa0", 64'(bus.wa[4:0]), 64'd9);
        check("t3_wd0", bus.wd[63:0], 64'hB);
        check("t3_wa1_unused", 64'(bus.wa[9:5]), 64'd0);
        check("t3_wd1_unused", bus.wd[127:64], 64'd0);
        tick(); clear_lanes(); #1;
        check("t3_count", 64'(bus.QueueCount), 64'd0);
        check("t3_x9",    shadow[9], 64'hB);

        // x0 write dropped.
        set_lane(0, 5'd0, 64'hFF); set_lane(2, 5'd3, 64'h33);
        #1;
        check("t4_we",  64'(bus.we), 64'd1);
        check("t4_wa0", 64'(bus.wa[4:0]), 64'd3);
        check("t4_wd0", bus.wd[63:0], 64'h33);
        tick(); clear_lanes(); #1;
        check("t4_count", 64'(bus.QueueCount), 64'd0);

        // Queued x4=1 superseded by new lane write x4=2.
        set_lane(0, 5'd20, 64'h20); set_lane(1, 5'd21, 64'h21); set_lane(2, 5'd4, 64'd1);
        #1;
        check("t5a_we", 64'(bus.we), 64'd3);
        tick(); clear_lanes();
        set_lane(0, 5'd4, 64'd2); set_lane(1, 5'd22, 64'h22); set_lane(2, 5'd23, 64'h23);
        #1;
        check("t5_count1",  64'(bus.QueueCount), 64'd1);
        check("t5_pend4",   64'(bus.PendingBusy), 64'h10);
        check("t5_wa0",     64'(bus.wa[4:0]), 64'd4);
        check("t5_wd0",     bus.wd[63:0], 64'd2);
        check("t5_wa1",     64'(bus.wa[9:5]), 64'd22);
        check("t5_wd1",     bus.wd[127:64], 64'h22);
        tick(); clear_lanes(); #1;
        check("t5_count_q", 64'(bus.QueueCount), 64'd1);
        check("t5_pend23",  64'(bus.PendingBusy), 64'h80_0000);
        check("t5_we_q",    64'(bus.we), 64'd1);
        check("t5_wa0_q",   64'(bus.wa[4:0]), 64'd23);
        tick(); #1;
        check("t5_count0",  64'(bus.QueueCount), 64'd0);
        check("t5_x4",      shadow[4], 64'd2);

        // Back-to-back full bundles reaching the stall threshold.
        set_bundle4(5'd1, 64'h61);
        tick(); clear_lanes(); set_bundle4(5'd10, 64'h6A);
        #1;
        check("t6_count2", 64'(bus.QueueCount), 64'd2);
        check("t6_stall2", 64'(bus.WbStall), 64'd0);
        tick(); clear_lanes(); #1;
        check("t6_count4", 64'(bus.QueueCount), 64'd4);
        check("t6_stall4", 64'(bus.WbStall), 64'd1);
        check("t6_pend4",  64'(bus.PendingBusy), 64'h3C00);
        bus.StallW = bus.WbStall;
        tick(); #1;
        check("t6_count_d", 64'(bus.QueueCount), 64'd2);
        bus.StallW = 1'b0;
        tick(); #1;
        check("t6_count_e", 64'(bus.QueueCount), 64'd0);

        // Random bundles throttled by WbStall against a sequential model.
        have = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (!have) begin
                for (int l = 0; l < 4; l++) begin
                    b_v[l]  = ($urandom_range(0, 3) != 0);
                    b_rd[l] = 5'($urandom_range(0, 15));
                    b_d[l]  = {32'(cyc), 32'($urandom)};
                end
                have = 1'b1;
            end
            clear_lanes();
            for (int l = 0; l < 4; l++) if (b_v[l]) set_lane(l, b_rd[l], b_d[l]);
            bus.StallW = bus.WbStall;
            #1;
            check("t6_qcount_le4", 64'(bus.QueueCount <= 3'd4), 64'd1);
            check("t6_stall_rel",  64'(bus.WbStall), 64'(bus.QueueCount >= 3'd3));
            if (!bus.StallW) begin
                for (int l = 0; l < 4; l++) begin
                    if (b_v[l] && b_rd[l] != 5'd0) begin
                        ref_rf[b_rd[l]] = b_d[l];
                        ref_w[b_rd[l]]  = 1'b1;
                    end
                end
                have = 1'b0;
            end
            tick();
        end
        clear_lanes(); bus.StallW = 1'b0;
        for (int i = 0; i < 10 && bus.QueueCount != 0; i++) tick();
        #1;
        check("t6_drained", 64'(bus.QueueCount), 64'd0);
        for (int r = 1; r < 32; r++) begin
            if (ref_w[r]) check($sformatf("t6_rf_x%0d", r), shadow[r], ref_rf[r]);
        end

        // Flushed bundle: only the queue drains.
        set_lane(0, 5'd24, 64'hC0); set_lane(1, 5'd25, 64'hC1);
        set_lane(2, 5'd26, 64'hC2); set_lane(3, 5'd27, 64'hC3);
        tick(); clear_lanes();
        set_lane(0, 5'd28, 64'hD0); set_lane(1, 5'd29, 64'hD1);
        set_lane(2, 5'd30, 64'hD2); set_lane(3, 5'd31, 64'hD3);
        bus.FlushW = 1'b1;
        #1;
        check("fl_count2", 64'(bus.QueueCount), 64'd2);
        check("fl_we",     64'(bus.we), 64'd3);
        check("fl_wa0",    64'(bus.wa[4:0]), 64'd26);
        check("fl_wa1",    64'(bus.wa[9:5]), 64'd27);
        tick(); #1;
        check("fl_count0", 64'(bus.QueueCount), 64'd0);
        check("fl_empty_we", 64'(bus.we), 64'd0);
        tick(); bus.FlushW = 1'b0; clear_lanes(); #1;
        check("fl_count_after", 64'(bus.QueueCount), 64'd0);
        check("fl_x28", shadow[28], 64'd0);

        check("no_dup_rd",    64'(dup_cnt), 64'd0);
        check("no_x0_writes", 64'(x0_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
